// File: rtl/lvds_7to1_rx_align.sv
// ---------------------------------------------------------------------------
// lvds_7to1_rx_align
// Word-alignment controller for the LVDS 7:1 receive path. It watches the
// deserialized clock-lane word. Until that word equals the 7:1 clock pattern,
// it issues single-cycle bit-slip pulses to the deserializers. Once the word
// is stable it forwards the data lanes with validity and lock status.
//
// Ports:
//   clkin      in   recovered pixel clock (single clock domain)
//   reset_n    in   asynchronous active-low reset
//   pll_lock   in   receive PLL lock, already synchronous to clkin
//   clk_word   in   [6:0] deserialized clock-lane word, MSB first
//   data_word  in   [7*NLANES-1:0] data lanes, lane i at [7i+6:7i]
//   calib      out  bit-slip pulse, one cycle high per slip
//   data_out   out  [7*NLANES-1:0] registered aligned data (0 when not locked)
//   data_valid out  data_out carries locked data
//   aligned    out  alignment achieved and held
//   slip_cnt   out  [2:0] slips issued in the current search, 0..6
//   align_err  out  sticky: seven slips failed to reach alignment
// ---------------------------------------------------------------------------
module lvds_7to1_rx_align #(
  parameter int         NLANES      = 4,
  parameter logic [6:0] CLK_PATTERN = 7'b1100011,
  parameter int         LOCK_WAIT   = 256,
  parameter int         MATCH_CNT   = 16,
  parameter int         SLIP_WAIT   = 4,
  parameter int         ERR_THRESH  = 4
) (
  input  logic                  clkin,
  input  logic                  reset_n,
  input  logic                  pll_lock,
  input  logic [6:0]            clk_word,
  input  logic [7*NLANES-1:0]   data_word,
  output logic                  calib,
  output logic [7*NLANES-1:0]   data_out,
  output logic                  data_valid,
  output logic                  aligned,
  output logic [2:0]            slip_cnt,
  output logic                  align_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    CHECK     = 3'd2,
    SLIP      = 3'd3,
    SETTLE    = 3'd4,
    LOCKED    = 3'd5
  } state_t;

  // Terminal values. Each counter stops at its limit and is then cleared by
  // the state transition, so it never wraps.
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_WAIT - 1);
  localparam logic [7:0]  MATCH_LAST  = 8'(MATCH_CNT - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SLIP_WAIT - 1);
  localparam logic [7:0]  ERR_LAST    = 8'(ERR_THRESH - 1);

  state_t                r_state, w_state_nxt;
  logic [15:0]           r_lock_cnt, w_lock_cnt_nxt;
  logic [7:0]            r_match_cnt, w_match_cnt_nxt;
  logic [7:0]            r_settle_cnt, w_settle_cnt_nxt;
  logic [7:0]            r_err_cnt, w_err_cnt_nxt;
  logic [2:0]            r_slip_cnt, w_slip_cnt_nxt;
  logic                  r_align_err, w_align_err_nxt;
  logic                  r_calib;
  logic                  r_aligned;
  logic                  r_data_valid;
  logic [7*NLANES-1:0]   r_data_out;
  logic                  w_match;
  logic                  w_locked;

  assign w_match  = (clk_word == CLK_PATTERN);
  // A lock drop in the current cycle already disqualifies the data, so the
  // valid/aligned flags fall on the very next edge.
  assign w_locked = (r_state == LOCKED) && pll_lock;

  // Next-state and counter update logic.
  always_comb begin
    w_state_nxt      = r_state;
    w_lock_cnt_nxt   = r_lock_cnt;
    w_match_cnt_nxt  = r_match_cnt;
    w_settle_cnt_nxt = r_settle_cnt;
    w_err_cnt_nxt    = r_err_cnt;
    w_slip_cnt_nxt   = r_slip_cnt;
    w_align_err_nxt  = r_align_err;
    if (!pll_lock && (r_state != IDLE)) begin
      // Loss of lock overrides everything; slip history is kept.
      w_state_nxt      = IDLE;
      w_lock_cnt_nxt   = 16'd0;
      w_match_cnt_nxt  = 8'd0;
      w_settle_cnt_nxt = 8'd0;
      w_err_cnt_nxt    = 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (pll_lock) begin
            w_state_nxt = WAIT_LOCK;
          end else begin
            w_state_nxt = IDLE;
          end
        end
        WAIT_LOCK: begin
          if (r_lock_cnt == LOCK_LAST) begin
            w_state_nxt     = CHECK;
            w_lock_cnt_nxt  = 16'd0;
            w_match_cnt_nxt = 8'd0;
          end else begin
            w_lock_cnt_nxt = r_lock_cnt + 16'd1;
          end
        end
        CHECK: begin
          if (!w_match) begin
            w_state_nxt     = SLIP;
            w_match_cnt_nxt = 8'd0;
          end else if (r_match_cnt == MATCH_LAST) begin
            w_state_nxt     = LOCKED;
            w_match_cnt_nxt = 8'd0;
            w_err_cnt_nxt   = 8'd0;
          end else begin
            w_match_cnt_nxt = r_match_cnt + 8'd1;
          end
        end
        SLIP: begin
          w_state_nxt      = SETTLE;
          w_settle_cnt_nxt = 8'd0;
          if (r_slip_cnt == 3'd6) begin
            // All seven phases tried without success.
            w_slip_cnt_nxt  = 3'd0;
            w_align_err_nxt = 1'b1;
          end else begin
            w_slip_cnt_nxt = r_slip_cnt + 3'd1;
          end
        end
        SETTLE: begin
          if (r_settle_cnt == SETTLE_LAST) begin
            w_state_nxt      = CHECK;
            w_settle_cnt_nxt = 8'd0;
            w_match_cnt_nxt  = 8'd0;
          end else begin
            w_settle_cnt_nxt = r_settle_cnt + 8'd1;
          end
        end
        LOCKED: begin
          w_align_err_nxt = 1'b0;
          if (w_match) begin
            w_err_cnt_nxt = 8'd0;
          end else if (r_err_cnt == ERR_LAST) begin
            w_state_nxt     = CHECK;
            w_err_cnt_nxt   = 8'd0;
            w_match_cnt_nxt = 8'd0;
          end else begin
            w_err_cnt_nxt = r_err_cnt + 8'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_lock_cnt   <= 16'd0;
      r_match_cnt  <= 8'd0;
      r_settle_cnt <= 8'd0;
      r_err_cnt    <= 8'd0;
      r_slip_cnt   <= 3'd0;
      r_align_err  <= 1'b0;
      r_calib      <= 1'b0;
      r_aligned    <= 1'b0;
      r_data_valid <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_match_cnt  <= w_match_cnt_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_err_cnt    <= w_err_cnt_nxt;
      r_slip_cnt   <= w_slip_cnt_nxt;
      r_align_err  <= w_align_err_nxt;
      // Registered from the next state so calib is high exactly in SLIP.
      r_calib      <= (w_state_nxt == SLIP);
      r_aligned    <= w_locked;
      r_data_valid <= w_locked;
      r_data_out   <= w_locked ? data_word : '0;
    end
  end

  assign calib      = r_calib;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign aligned    = r_aligned;
  assign slip_cnt   = r_slip_cnt;
  assign align_err  = r_align_err;

endmodule
